// File: rtl/johnson_sequence_monitor_pkg.sv
// Shared definitions for the Johnson sequence monitor.
//   - FSM state encoding (matches the 2-bit state output)
//   - the eight legal codes of the 4-bit count-down Johnson ring, in phase order
//   - johnson_next(): successor of a code on that ring
package johnson_pkg;

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_TRACK  = 2'd1,
      ST_LOCKED = 2'd2,
      ST_FAULT  = 2'd3
   } jsm_state_t;

   localparam logic [3:0] CODE_0 = 4'b0000;
   localparam logic [3:0] CODE_1 = 4'b1000;
   localparam logic [3:0] CODE_2 = 4'b1100;
   localparam logic [3:0] CODE_3 = 4'b1110;
   localparam logic [3:0] CODE_4 = 4'b1111;
   localparam logic [3:0] CODE_5 = 4'b0111;
   localparam logic [3:0] CODE_6 = 4'b0011;
   localparam logic [3:0] CODE_7 = 4'b0001;

   // The ring shifts right and feeds the inverted LSB into the MSB.
   // Only meaningful for legal codes; callers qualify with legality.
   function automatic logic [3:0] johnson_next(input logic [3:0] code);
      return {~code[0], code[3:1]};
   endfunction

endpackage

// File: rtl/johnson_sequence_monitor_if.sv
// Bundle between the Johnson counter side and the sequence monitor.
//   master : drives code_in / sample_en / clr_fault, observes status
//   slave  : the monitor itself
//   code_in[3:0]    counter output          sample_en   code_in valid this cycle
//   clr_fault       leave FAULT             index[2:0]  phase of last legal sample
//   code_legal      last sample legal       locked      FSM in LOCKED
//   fault           FSM in FAULT            wrap_pulse  one pulse per ring while locked
//   wrap_count      saturating ring count   state[1:0]  raw FSM state
interface johnson_sequence_monitor_if #(
   parameter int WRAP_W = 8
);
   logic [3:0]        code_in;
   logic              sample_en;
   logic              clr_fault;
   logic [2:0]        index;
   logic              code_legal;
   logic              locked;
   logic              fault;
   logic              wrap_pulse;
   logic [WRAP_W-1:0] wrap_count;
   logic [1:0]        state;

   modport master (
      output code_in, sample_en, clr_fault,
      input  index, code_legal, locked, fault, wrap_pulse, wrap_count, state
   );

   modport slave (
      input  code_in, sample_en, clr_fault,
      output index, code_legal, locked, fault, wrap_pulse, wrap_count, state
   );
endinterface

// File: rtl/johnson_sequence_monitor_decode.sv
// Combinational decode of a 4-bit Johnson code to its phase index.
//   code_i[3:0]  raw counter code
//   index_o[2:0] phase 0..7 (0 when illegal)
//   legal_o      code is one of the eight ring codes
module johnson_decode
   import johnson_pkg::*;
(
   input  logic [3:0] code_i,
   output logic [2:0] index_o,
   output logic       legal_o
);

   always_comb begin
      index_o = 3'd0;
      legal_o = 1'b1;
      case (code_i)
         CODE_0:  index_o = 3'd0;
         CODE_1:  index_o = 3'd1;
         CODE_2:  index_o = 3'd2;
         CODE_3:  index_o = 3'd3;
         CODE_4:  index_o = 3'd4;
         CODE_5:  index_o = 3'd5;
         CODE_6:  index_o = 3'd6;
         CODE_7:  index_o = 3'd7;
         default: legal_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/johnson_sequence_monitor.sv
// Self-checking consumer of the 4-bit count-down Johnson counter.
// Classifies each enabled sample against the stored previous code, locks
// after LOCK_COUNT consecutive forward steps, counts ring wraps while locked
// and latches a sticky fault on any corruption once locked.
//   clk    system clock
//   reset  synchronous active-low reset
//   bus    johnson_sequence_monitor_if slave modport (see interface file)
//
// state  | meaning
// -------+------------------------------------------------------------
// SEARCH | no reference code yet; first legal sample starts tracking
// TRACK  | counting forward steps toward lock; HOLD ignored, BAD drops out
// LOCKED | ring verified; STEP/HOLD ok, BAD goes to FAULT, wraps counted
// FAULT  | sticky; samples ignored until clr_fault
module johnson_sequence_monitor
   import johnson_pkg::*;
#(
   parameter int LOCK_COUNT = 4,
   parameter int WRAP_W     = 8
) (
   input  logic clk,
   input  logic reset,
   johnson_sequence_monitor_if.slave bus
);

   localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);

   jsm_state_t        state_q, state_d;
   logic [2:0]        index_q, index_d;
   logic              code_legal_q, code_legal_d;
   logic              wrap_pulse_q, wrap_pulse_d;
   logic [WRAP_W-1:0] wrap_count_q, wrap_count_d;
   logic [3:0]        prev_code_q, prev_code_d;
   logic              prev_valid_q, prev_valid_d;
   logic [3:0]        streak_q, streak_d;

   logic [2:0] dec_index;
   logic       dec_legal;
   logic       is_step;
   logic       is_hold;

   johnson_decode u_decode (
      .code_i  (bus.code_in),
      .index_o (dec_index),
      .legal_o (dec_legal)
   );

   // prev_code_q only ever holds legal codes, so a HOLD is implicitly legal.
   assign is_step = prev_valid_q && dec_legal && (bus.code_in == johnson_next(prev_code_q));
   assign is_hold = prev_valid_q && (bus.code_in == prev_code_q);

   always_comb begin
      state_d      = state_q;
      index_d      = index_q;
      code_legal_d = code_legal_q;
      wrap_pulse_d = 1'b0;
      wrap_count_d = wrap_count_q;
      prev_code_d  = prev_code_q;
      prev_valid_d = prev_valid_q;
      streak_d     = streak_q;

      if (state_q == ST_FAULT) begin
         // Any sample arriving with clr_fault is discarded.
         if (bus.clr_fault) begin
            state_d      = ST_SEARCH;
            prev_valid_d = 1'b0;
         end
      end else if (bus.sample_en) begin
         code_legal_d = dec_legal;
         if (dec_legal) begin
            index_d     = dec_index;
            prev_code_d = bus.code_in;
         end

         if (state_q == ST_SEARCH) begin
            if (dec_legal) begin
               state_d      = ST_TRACK;
               streak_d     = 4'd0;
               prev_valid_d = 1'b1;
            end
         end else if (state_q == ST_TRACK) begin
            if (is_step) begin
               streak_d = streak_q + 4'd1;
               if (streak_q + 4'd1 == LOCK_N) begin
                  state_d = ST_LOCKED;
               end
            end else if (!is_hold) begin
               state_d      = ST_SEARCH;
               streak_d     = 4'd0;
               prev_valid_d = 1'b0;
            end
         end else begin
            if (is_step) begin
               // Only a 0001 -> 0000 step lands on CODE_0.
               if (bus.code_in == CODE_0) begin
                  wrap_pulse_d = 1'b1;
                  if (wrap_count_q != {WRAP_W{1'b1}}) begin
                     wrap_count_d = wrap_count_q + WRAP_W'(1);
                  end
               end
            end else if (!is_hold) begin
               state_d = ST_FAULT;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= ST_SEARCH;
         index_q      <= 3'd0;
         code_legal_q <= 1'b0;
         wrap_pulse_q <= 1'b0;
         wrap_count_q <= '0;
         prev_code_q  <= CODE_0;
         prev_valid_q <= 1'b0;
         streak_q     <= 4'd0;
      end else begin
         state_q      <= state_d;
         index_q      <= index_d;
         code_legal_q <= code_legal_d;
         wrap_pulse_q <= wrap_pulse_d;
         wrap_count_q <= wrap_count_d;
         prev_code_q  <= prev_code_d;
         prev_valid_q <= prev_valid_d;
         streak_q     <= streak_d;
      end
   end

   assign bus.state      = state_q;
   assign bus.index      = index_q;
   assign bus.code_legal = code_legal_q;
   assign bus.locked     = (state_q == ST_LOCKED);
   assign bus.fault      = (state_q == ST_FAULT);
   assign bus.wrap_pulse = wrap_pulse_q;
   assign bus.wrap_count = wrap_count_q;

endmodule

// File: tb/tb_johnson_sequence_monitor.sv
// Bench for johnson_sequence_monitor: two instances (WRAP_W=8 and WRAP_W=2)
// driven with identical stimulus and compared against a phase-index model.
module tb_johnson_sequence_monitor;

   localparam int LOCK_COUNT = 4;

   logic clk;
   logic reset;

   johnson_sequence_monitor_if #(.WRAP_W(8)) b8 ();
   johnson_sequence_monitor_if #(.WRAP_W(2)) b2 ();

   johnson_sequence_monitor #(.LOCK_COUNT(LOCK_COUNT), .WRAP_W(8)) u_dut8 (
      .clk   (clk),
      .reset (reset),
      .bus   (b8)
   );

   johnson_sequence_monitor #(.LOCK_COUNT(LOCK_COUNT), .WRAP_W(2)) u_dut2 (
      .clk   (clk),
      .reset (reset),
      .bus   (b2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [3:0] ring [8];

   // Reference model state, in ring-phase terms.
   int m_mode;        // 0 search, 1 track, 2 locked, 3 fault
   int m_index;
   bit m_legal;
   bit m_pulse;
   int m_wc8;
   int m_wc2;
   int m_prev_idx;
   bit m_prev_valid;
   int m_streak;

   function automatic int code_index(input logic [3:0] c);
      for (int i = 0; i < 8; i++) begin
         if (ring[i] == c) return i;
      end
      return -1;
   endfunction

   task automatic model_step(input bit rst, input bit en, input logic [3:0] code, input bit clr);
      int  idx;
      bit  step;
      bit  hold;
      if (rst) begin
         m_mode = 0; m_index = 0; m_legal = 0; m_pulse = 0;
         m_wc8 = 0; m_wc2 = 0; m_prev_idx = 0; m_prev_valid = 0; m_streak = 0;
         return;
      end
      m_pulse = 0;
      if (m_mode == 3) begin
         if (clr) begin
            m_mode = 0;
            m_prev_valid = 0;
         end
         return;
      end
      if (!en) return;
      idx  = code_index(code);
      step = m_prev_valid && (idx >= 0) && (idx == (m_prev_idx + 1) % 8);
      hold = m_prev_valid && (idx >= 0) && (idx == m_prev_idx);
      m_legal = (idx >= 0);
      if (idx >= 0) begin
         m_index    = idx;
         m_prev_idx = idx;
      end
      case (m_mode)
         0: if (idx >= 0) begin
               m_mode = 1; m_streak = 0; m_prev_valid = 1;
            end
         1: if (step) begin
               m_streak++;
               if (m_streak == LOCK_COUNT) m_mode = 2;
            end else if (!hold) begin
               m_mode = 0; m_streak = 0; m_prev_valid = 0;
            end
         2: if (step) begin
               if (idx == 0) begin
                  m_pulse = 1;
                  if (m_wc8 < 255) m_wc8++;
                  if (m_wc2 < 3) m_wc2++;
               end
            end else if (!hold) begin
               m_mode = 3;
            end
         default: ;
      endcase
   endtask

   function automatic logic [27:0] exp_vec();
      logic [8:0] core;
      core = {2'(m_mode), 3'(m_index), m_legal, (m_mode == 2), (m_mode == 3), m_pulse};
      return {core, 8'(m_wc8), core, 2'(m_wc2)};
   endfunction

   function automatic logic [27:0] obs_vec();
      return {b8.state, b8.index, b8.code_legal, b8.locked, b8.fault, b8.wrap_pulse, b8.wrap_count,
              b2.state, b2.index, b2.code_legal, b2.locked, b2.fault, b2.wrap_pulse, b2.wrap_count};
   endfunction

   // Drive one clock of stimulus to both instances and advance the model.
   task automatic cycle(input bit rst, input bit en, input logic [3:0] code, input bit clr);
      reset        = !rst;
      b8.code_in   = code; b8.sample_en = en; b8.clr_fault = clr;
      b2.code_in   = code; b2.sample_en = en; b2.clr_fault = clr;
      model_step(rst, en, code, clr);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'($urandom), 4'($urandom), 1'($urandom));
      cycle(1'b0, 1'b0, 4'hA, 1'b0);
      n_tests++;
      if (obs_vec() !== 28'h0) begin
         n_fail++;
         $display("FAIL reset_outputs got=%h exp=%h", obs_vec(), 28'h0);
      end
   endtask

   task automatic test_lock_and_wrap();
      for (int i = 0; i < 10; i++) begin
         cycle(1'b0, 1'b1, ring[i % 8], 1'b0);
         n_tests++;
         if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL lock_model step=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
         end
         if (i == 0) begin
            n_tests++;
            if (b8.state !== 2'd1) begin
               n_fail++;
               $display("FAIL first_sample_track got=%0d exp=1", b8.state);
            end
         end
         if (i == 3 || i == 4) begin
            n_tests++;
            if (b8.locked !== (i == 4)) begin
               n_fail++;
               $display("FAIL lock_point sample=%0d got=%0b exp=%0b", i + 1, b8.locked, (i == 4));
            end
         end
         if (i == 8) begin
            n_tests++;
            if ({b8.wrap_pulse, b8.wrap_count} !== {1'b1, 8'd1}) begin
               n_fail++;
               $display("FAIL first_wrap got=%b/%0d exp=1/1", b8.wrap_pulse, b8.wrap_count);
            end
         end
         if (i == 9) begin
            n_tests++;
            if (b8.wrap_pulse !== 1'b0) begin
               n_fail++;
               $display("FAIL wrap_pulse_width got=%b exp=0", b8.wrap_pulse);
            end
         end
      end
   endtask

   task automatic test_fault();
      cycle(1'b0, 1'b1, 4'b1100, 1'b0);
      cycle(1'b0, 1'b1, 4'b1110, 1'b0);
      cycle(1'b0, 1'b1, 4'b0100, 1'b0);
      n_tests++;
      if ({b8.fault, b8.state, b8.code_legal, b8.index} !== {1'b1, 2'd3, 1'b0, 3'd3}) begin
         n_fail++;
         $display("FAIL fault_entry got=%b/%0d/%b/%0d exp=1/3/0/3",
                  b8.fault, b8.state, b8.code_legal, b8.index);
      end
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, ring[(5 + i) % 8], 1'b0);
      n_tests++;
      if ({b8.index, b8.wrap_count, b8.state} !== {3'd3, 8'd1, 2'd3}) begin
         n_fail++;
         $display("FAIL fault_frozen got=%0d/%0d/%0d exp=3/1/3", b8.index, b8.wrap_count, b8.state);
      end
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL fault_model got=%h exp=%h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_clear();
      cycle(1'b0, 1'b1, 4'b1000, 1'b1);
      n_tests++;
      if ({b8.state, b8.index} !== {2'd0, 3'd3}) begin
         n_fail++;
         $display("FAIL clear_discard got=%0d/%0d exp=0/3", b8.state, b8.index);
      end
      cycle(1'b0, 1'b1, 4'b1000, 1'b0);
      n_tests++;
      if ({b8.state, b8.index} !== {2'd1, 3'd1}) begin
         n_fail++;
         $display("FAIL clear_retrack got=%0d/%0d exp=1/1", b8.state, b8.index);
      end
   endtask

   task automatic test_hold_and_skip();
      for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 4'b1100, 1'b0);
      n_tests++;
      if ({b8.state, b8.locked} !== {2'd1, 1'b0}) begin
         n_fail++;
         $display("FAIL hold_no_lock got=%0d/%b exp=1/0", b8.state, b8.locked);
      end
      cycle(1'b0, 1'b1, 4'b1111, 1'b0);
      n_tests++;
      if (b8.state !== 2'd0) begin
         n_fail++;
         $display("FAIL skip_to_search got=%0d exp=0", b8.state);
      end
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL skip_model got=%h exp=%h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_wrap_saturation();
      int pulses;
      pulses = 0;
      cycle(1'b1, 1'b0, 4'h0, 1'b0);
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, ring[i], 1'b0);
      for (int i = 0; i < 40; i++) begin
         cycle(1'b0, 1'b1, ring[(5 + i) % 8], 1'b0);
         if (b2.wrap_pulse === 1'b1) pulses++;
      end
      n_tests++;
      if ({b2.wrap_count, b8.wrap_count} !== {2'd3, 8'd5}) begin
         n_fail++;
         $display("FAIL wrap_saturate got=%0d/%0d exp=3/5", b2.wrap_count, b8.wrap_count);
      end
      n_tests++;
      if (pulses != 5) begin
         n_fail++;
         $display("FAIL wrap_pulse_count got=%0d exp=5", pulses);
      end
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, ring[(5 + i) % 8], 1'b0);
      cycle(1'b1, 1'b1, ring[0], 1'b1);
      n_tests++;
      if (obs_vec() !== 28'h0) begin
         n_fail++;
         $display("FAIL midrun_reset got=%h exp=%h", obs_vec(), 28'h0);
      end
   endtask

   task automatic test_random();
      int r;
      logic [3:0] code;
      for (int i = 0; i < 2000; i++) begin
         r = int'($urandom_range(0, 99));
         if (r < 65)      code = ring[(m_prev_idx + 1) % 8];
         else if (r < 78) code = ring[m_prev_idx];
         else             code = 4'($urandom_range(0, 15));
         cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0), code,
               ($urandom_range(0, 15) == 0));
         n_tests++;
         if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL random_model cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
         end
      end
   endtask

   initial begin
      ring = '{4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001};
      reset = 1'b0;
      b8.code_in = 4'h0; b8.sample_en = 1'b0; b8.clr_fault = 1'b0;
      b2.code_in = 4'h0; b2.sample_en = 1'b0; b2.clr_fault = 1'b0;
      model_step(1'b1, 1'b0, 4'h0, 1'b0);

      test_reset();
      test_lock_and_wrap();
      test_fault();
      test_clear();
      test_hold_and_skip();
      test_wrap_saturation();
      test_random();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/johnson_sequence_monitor.md
Name: johnson_sequence_monitor

Overview:
- Sits directly downstream of the 4-bit count-down Johnson counter.
- Samples the counter's 4-bit output, decodes it to a 3-bit phase index and checks every sample against the legal 8-state Johnson ring.
- Locks after a run of correct steps, counts full ring wraps, and raises a sticky fault on any corruption once locked.
- Used as the self-checking consumer of the counter in board and bench builds.

Parameters:
- LOCK_COUNT, 4, consecutive legal forward steps required to move TRACK -> LOCKED (1..15).
- WRAP_W, 8, width of the saturating wrap counter.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-low reset; sampled on posedge clk.
- code_in  input  4  Johnson counter output.
- sample_en  input  1  code_in is valid and evaluated this cycle.
- clr_fault  input  1  leaves FAULT and returns to SEARCH.
- index  output  3  decoded phase of the last legal sample.
- code_legal  output  1  last sample was one of the 8 legal codes.
- locked  output  1  FSM is in LOCKED.
- fault  output  1  FSM is in FAULT (sticky).
- wrap_pulse  output  1  one-cycle pulse per completed ring while LOCKED.
- wrap_count  output  WRAP_W  number of completed rings, saturating.
- state  output  2  FSM state: SEARCH=0, TRACK=1, LOCKED=2, FAULT=3.

Behaviour:
- Legal ring, index order: 0000=0, 1000=1, 1100=2, 1110=3, 1111=4, 0111=5, 0011=6, 0001=7. Successor of 7 is 0. The other 8 codes are illegal.
- Reset (reset==0 at posedge) has priority over everything:
  - state=SEARCH; index=0, code_legal=0, locked=0, fault=0, wrap_pulse=0, wrap_count=0.
  - Stored previous code = 0000, prev_valid=0.
- Cycles with sample_en==0: no state, index, legality or counter change; wrap_pulse=0.
- Latency: a sample taken at posedge N is reflected in all outputs after posedge N (registered, 1 cycle).
- Sample classification, relative to the stored previous code:
  - STEP: legal code equal to the successor of the previous code.
  - HOLD: code equal to the previous code.
  - BAD: illegal code, or any other legal jump (including skip or backward).
- On a legal sample: index and the previous code update, code_legal=1. On an illegal sample: index holds, previous code holds, code_legal=0.
- SEARCH:
  - Legal code -> TRACK, streak=0, prev_valid=1.
  - Illegal code -> stay in SEARCH.
- TRACK:
  - STEP -> streak+1; when streak reaches LOCK_COUNT -> LOCKED.
  - HOLD -> no change.
  - BAD -> SEARCH, streak=0, prev_valid=0.
- LOCKED:
  - STEP -> stay in LOCKED.
  - HOLD -> stay in LOCKED.
  - BAD -> FAULT, fault=1.
- FAULT:
  - Absorbing until clr_fault is asserted. Samples are ignored, index is frozen and wrap_count is frozen.
- clr_fault:
  - In FAULT: clr_fault=1 -> SEARCH, prev_valid=0, wrap_count holds.
  - If sample_en is high in the same cycle, the sample is discarded.
  - clr_fault has no effect outside FAULT.
- Wrap:
  - A STEP from 0001 to 0000 while already LOCKED asserts wrap_pulse for exactly one cycle.
  - The same step increments wrap_count, saturating at 2^WRAP_W-1.
  - The step that causes the lock does not count as a wrap.
- Upstream counter reset mid-run (jump to 0000 from any index other than 7):
  - In TRACK it is BAD -> SEARCH.
  - In LOCKED it is BAD -> FAULT.
- Reset asserted mid-run: state clears on that edge regardless of sample_en or clr_fault.

Decomposition:
- Shared package johnson_pkg holds:
  - State encodings SEARCH/TRACK/LOCKED/FAULT.
  - The 8 legal code constants.
  - Function johnson_next(code) giving the successor for the count-down ring.
- One sub-module johnson_decode (code[3:0] -> index[2:0], legal), purely combinational.
- Instantiate johnson_decode once for code_in. The successor check uses johnson_next on the stored code.

Test Plan:
- Reset held 3 cycles, then released with sample_en=0 -> all outputs 0 and state=0.
- Feed the full legal sequence from 0000, sample_en=1 every cycle, LOCK_COUNT=4:
  - state=1 after the first sample.
  - locked=1 after the 5th sample (1111).
  - wrap_pulse on the 0001->0000 step.
  - wrap_count=1 after 9 further samples.
- While LOCKED at index 3 (1110), drive 0100 -> fault=1, state=3, code_legal=0, index stays 3. Further samples do not change index or wrap_count.
- In FAULT, pulse clr_fault together with sample_en and code 1000 -> state=0 on that edge, sample discarded. The next legal sample gives state=1.
- In TRACK, hold code 1100 for 5 samples (HOLD) -> no lock. Then jump 1100 -> 1111 (skip) -> state=0.
- WRAP_W=2, run 5 full rings after lock -> wrap_count saturates at 3 and wrap_pulse still fires each ring. Reset asserted mid-ring clears everything on the same edge.
